// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency multiply, multiply-accumulate
// and divide operations, plus direct HI/LO moves, with cancel and asynchronous reset.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       start,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             md_write,
  input  logic             md_sel_hi,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] rdata
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;

  logic [W2-1:0]    acc, prod_u, prod_s;
  logic             is_sdiv, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign acc    = {hi_reg, lo_reg};
  assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
  assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};

  // Signed divide runs on magnitudes; most-negative / -1 falls out naturally.
  assign is_sdiv = (op_reg == 3'd4);
  assign a_neg   = is_sdiv & a_reg[WIDTH-1];
  assign b_neg   = is_sdiv & b_reg[WIDTH-1];
  assign a_mag   = a_neg ? -a_reg : a_reg;
  assign b_mag   = b_neg ? -b_reg : b_reg;
  assign b_safe  = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_wr = 1'b1;
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (op_reg)
      3'd1:       {res_hi, res_lo} = prod_u;
      3'd2:       {res_hi, res_lo} = prod_s;
      3'd3, 3'd4: begin
        res_wr = (b_reg != '0);
        res_hi = rem;
        res_lo = quot;
      end
      3'd5:       {res_hi, res_lo} = acc + prod_u;
      3'd6:       {res_hi, res_lo} = acc + prod_s;
      3'd7:       {res_hi, res_lo} = acc - prod_s;
      default:    res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (!cancel) begin
          if (md_write) begin
            if (md_sel_hi) hi_next = rs_val;
            else           lo_next = rs_val;
          end else if (start != 3'd0) begin
            state_next = RUN;
            op_next    = start;
            a_next     = rs_val;
            b_next     = rt_val;
            cnt_next   = (start == 3'd3 || start == 3'd4) ? DIV_CNT : MULT_CNT;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg <= 4'd1) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (res_wr) begin
            hi_next = res_hi;
            lo_next = res_lo;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy  = (state_reg == RUN);
  assign rdata = md_sel_hi ? hi_reg : lo_reg;

endmodule
